// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The issuing stage decodes MULT/DIV opcodes into start_mult/start_div.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  localparam logic [4:0] MULT = 5'b00110;
  localparam logic [4:0] DIV  = 5'b00111;

  localparam int MIN_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/md_exec_unit_if.sv
// Issue-side bus of the multiply/divide unit: start requests and operands in,
// held result, qualifiers and pipeline stall out.
interface md_exec_unit_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic             flush;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             result_rdy;
  logic             exception;
  logic             busy;
  logic             stall;

  modport master (
    output start_mult, start_div, flush, operand_a, operand_b,
    input  result, result_rdy, exception, busy, stall
  );

  modport slave (
    input  start_mult, start_div, flush, operand_a, operand_b,
    output result, result_rdy, exception, busy, stall
  );
endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the finished result.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic [WIDTH-1:0] y
);
  assign y = en ? (~a + WIDTH'(1)) : a;
endmodule

// File: rtl/md_exec_unit.sv
// Radix-2 sequential multiply/divide for the execute stage. Works on operand
// magnitudes for WIDTH cycles, then sign-fixes and publishes in DONE.
module md_exec_unit
  import md_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic      clock,
  input logic      clrn,
  md_exec_unit_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             op_div, neg_res, dz;
  logic [WIDTH-1:0] opnd;
  // mult: {carry/high, multiplier shifting out}; div: {partial remainder, quotient}
  logic [2*WIDTH:0] acc, acc_step;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shl;
  logic [2*WIDTH-1:0] fix_in, fixed;
  logic [WIDTH-1:0]   res_new;
  logic               exc_new, start, done_ok;

  md_negate #(.WIDTH(WIDTH)) u_mag_a (
    .a(bus.operand_a), .en(SIGNED & bus.operand_a[WIDTH-1]), .y(a_mag));
  md_negate #(.WIDTH(WIDTH)) u_mag_b (
    .a(bus.operand_b), .en(SIGNED & bus.operand_b[WIDTH-1]), .y(b_mag));

  always_comb begin
    sum      = '0;
    shl      = '0;
    acc_step = acc;
    if (op_div) begin
      shl = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      if (shl >= {1'b0, opnd}) acc_step = {shl - {1'b0, opnd}, acc[WIDTH-2:0], 1'b1};
      else                     acc_step = {shl, acc[WIDTH-2:0], 1'b0};
    end else begin
      sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
      acc_step = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

  // Full-width fix-up so multiply overflow can be judged on the signed product.
  assign fix_in = op_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc[2*WIDTH-1:0];
  md_negate #(.WIDTH(2*WIDTH)) u_fix (.a(fix_in), .en(neg_res), .y(fixed));

  always_comb begin
    res_new = dz ? '0 : fixed[WIDTH-1:0];
    exc_new = 1'b0;
    if (dz)          exc_new = 1'b1;
    else if (op_div) exc_new = SIGNED & ~neg_res & acc[WIDTH-1];
    else if (SIGNED) exc_new = fixed[2*WIDTH-1:WIDTH] != {WIDTH{fixed[WIDTH-1]}};
    else             exc_new = fixed[2*WIDTH-1:WIDTH] != '0;
  end

  assign start   = (bus.start_mult | bus.start_div) & (state == IDLE) & ~bus.flush;
  assign done_ok = (state == DONE) & ~bus.flush;

  // A flush landing in DONE must leave the visible result untouched, so the
  // new value is only shown through the held register in unflushed DONE.
  assign bus.result     = done_ok ? res_new : result_q;
  assign bus.exception  = done_ok ? exc_new : exc_q;
  assign bus.result_rdy = done_ok;
  assign bus.busy       = (state == CALC);
  assign bus.stall      = start | bus.busy;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      dz       <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          op_div  <= ~bus.start_mult;
          neg_res <= SIGNED & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
          if (bus.start_mult) begin
            opnd  <= a_mag;
            acc   <= {{(WIDTH+1){1'b0}}, b_mag};
            dz    <= 1'b0;
            state <= CALC;
          end else begin
            opnd  <= b_mag;
            acc   <= {{(WIDTH+1){1'b0}}, a_mag};
            dz    <= (bus.operand_b == '0);
            state <= (bus.operand_b == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= DONE;
        end
        DONE: begin
          result_q <= res_new;
          exc_q    <= exc_new;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_exec_unit.sv
// Randomized scoreboard bench for md_exec_unit: a signed and an unsigned
// instance, expected results from plain integer arithmetic.
module tb_md_exec_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic clrn  = 1'b0;
  always #5 clock = ~clock;

  md_exec_unit_if #(.WIDTH(W)) bs ();
  md_exec_unit_if #(.WIDTH(W)) bu ();

  md_exec_unit #(.WIDTH(W), .SIGNED(1'b1)) dut_s (.clock(clock), .clrn(clrn), .bus(bs));
  md_exec_unit #(.WIDTH(W), .SIGNED(1'b0)) dut_u (.clock(clock), .clrn(clrn), .bus(bu));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           due;
  } exp_t;

  exp_t         q_s[$], q_u[$];
  logic [W-1:0] last_res[2];
  logic         last_exc[2];
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic drive(input bit uns, input bit sm, input bit sd, input bit fl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (uns) begin
      bu.start_mult = sm; bu.start_div = sd; bu.flush = fl; bu.operand_a = a; bu.operand_b = b;
    end else begin
      bs.start_mult = sm; bs.start_div = sd; bs.flush = fl; bs.operand_a = a; bs.operand_b = b;
    end
  endtask

  function automatic logic o_stall(input bit uns); return uns ? bu.stall : bs.stall; endfunction
  function automatic logic o_busy(input bit uns);  return uns ? bu.busy  : bs.busy;  endfunction
  function automatic logic o_rdy(input bit uns);   return uns ? bu.result_rdy : bs.result_rdy; endfunction
  function automatic logic o_exc(input bit uns);   return uns ? bu.exception  : bs.exception;  endfunction
  function automatic logic [W-1:0] o_res(input bit uns); return uns ? bu.result : bs.result; endfunction

  // Reference: plain integer arithmetic on the architectural values.
  task automatic model(input bit uns, input bit div, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic e);
    int          sa, sb, q;
    longint      p;
    logic [63:0] pu;
    sa = a; sb = b;
    if (div) begin
      if (b == 0) begin r = '0; e = 1'b1; end
      else if (uns) begin r = a / b; e = 1'b0; end
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; e = 1'b1; end
      else begin q = sa / sb; r = q; e = 1'b0; end
    end else if (uns) begin
      pu = {32'b0, a} * {32'b0, b};
      r = pu[W-1:0]; e = |pu[63:W];
    end else begin
      p = longint'(sa) * longint'(sb);
      r = p[W-1:0];
      e = (p != longint'(int'(r)));
    end
  endtask

  task automatic pop_check(input bit uns);
    exp_t x;
    if (uns ? (q_u.size() == 0) : (q_s.size() == 0)) begin
      check("rdy_unexpected", o_rdy(uns), 0);
      return;
    end
    x = uns ? q_u.pop_front() : q_s.pop_front();
    check(uns ? "u_result" : "s_result", o_res(uns), x.res);
    check(uns ? "u_exception" : "s_exception", o_exc(uns), x.exc);
    check(uns ? "u_rdy_cycle" : "s_rdy_cycle", cyc, x.due);
    last_res[uns] = x.res;
    last_exc[uns] = x.exc;
  endtask

  task automatic run_op(input bit uns, input bit div, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hold);
    exp_t x;
    int   lat;
    model(uns, div, a, b, x.res, x.exc);
    lat   = (div && b == 0) ? 1 : W + 1;
    x.due = cyc + lat;
    if (uns) q_u.push_back(x); else q_s.push_back(x);
    drive(uns, ~div, div, 1'b0, a, b);
    #1;
    check("stall_c0", o_stall(uns), 1);
    check("busy_c0", o_busy(uns), 0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;
      if (!hold) drive(uns, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      check("stall", o_stall(uns), (k < lat) ? 1 : 0);
      check("busy", o_busy(uns), (k < lat) ? 1 : 0);
    end
    @(posedge clock); #1;
    drive(uns, 1'b0, 1'b0, 1'b0, '0, '0);
    check("idle_after", o_busy(uns), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: begin v = $urandom_range(1, 20); if ($urandom_range(0, 1) == 1) v = -v; end
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    drive(1'b0, 0, 0, 0, '0, '0);
    drive(1'b1, 0, 0, 0, '0, '0);
    last_res[0] = '0; last_res[1] = '0; last_exc[0] = 1'b0; last_exc[1] = 1'b0;
    fork
      forever begin
        @(negedge clock);
        if (bs.result_rdy) pop_check(1'b0);
        if (bu.result_rdy) pop_check(1'b1);
      end
    join_none

    #3;
    for (int u = 0; u < 2; u++) begin
      check("rst_result", o_res(u[0]), 0);
      check("rst_exc", o_exc(u[0]), 0);
      check("rst_rdy", o_rdy(u[0]), 0);
      check("rst_busy", o_busy(u[0]), 0);
      check("rst_stall", o_stall(u[0]), 0);
    end
    repeat (2) @(posedge clock);
    #3 clrn = 1'b1;
    @(posedge clock); #1;

    // Directed cases
    run_op(0, 0, 32'd7, -32'sd6, 0);
    run_op(0, 1, -32'sd100, 32'd7, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(0, 1, 32'd5, 32'd0, 0);
    run_op(0, 0, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(1, 0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(1, 1, 32'hFFFF_FFF0, 32'd3, 0);

    // Flush during divide, ignored mid-CALC start, restart at relative cycle 12
    drive(0, 0, 1, 0, 32'd1000, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (k == 1) drive(0, 0, 0, 0, 32'd1, 32'd1);
      if (k == 5) drive(0, 0, 1, 0, 32'd9, 32'd0);
      if (k == 6) drive(0, 0, 0, 0, 32'd1, 32'd1);
      if (k == 10) begin
        check("busy_before_flush", bs.busy, 1);
        drive(0, 0, 0, 1, 32'd1, 32'd1);
      end
      if (k == 11) begin
        drive(0, 0, 0, 0, 32'd1, 32'd1);
        #1;
        check("flush_busy", bs.busy, 0);
        check("flush_stall", bs.stall, 0);
        check("flush_result_held", bs.result, last_res[0]);
        check("flush_exc_held", bs.exception, last_exc[0]);
      end
    end
    run_op(0, 0, 32'd3, 32'd4, 0);

    // Flush in IDLE suppresses the start
    drive(0, 1, 0, 1, 32'd2, 32'd2);
    #1 check("idle_flush_stall", bs.stall, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, '0, '0);
    check("idle_flush_busy", bs.busy, 0);

    // Flush in DONE: no ready, result unchanged
    drive(0, 1, 0, 0, 32'd11, 32'd13);
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clock); #1;
      if (k == 1) drive(0, 0, 0, 0, '0, '0);
    end
    drive(0, 0, 0, 1, '0, '0);
    #1;
    check("done_flush_rdy", bs.result_rdy, 0);
    check("done_flush_result", bs.result, last_res[0]);
    @(posedge clock); #1;
    drive(0, 0, 0, 0, '0, '0);
    check("done_flush_after", bs.result, last_res[0]);

    // Asynchronous reset in the middle of a multiply
    drive(0, 1, 0, 0, 32'd123, 32'd456);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      if (k == 1) drive(0, 0, 0, 0, '0, '0);
    end
    #2 clrn = 1'b0;
    #1;
    check("mid_rst_result", bs.result, 0);
    check("mid_rst_exc", bs.exception, 0);
    check("mid_rst_busy", bs.busy, 0);
    check("mid_rst_stall", bs.stall, 0);
    check("mid_rst_rdy", bs.result_rdy, 0);
    last_res[0] = '0; last_exc[0] = 1'b0; last_res[1] = '0; last_exc[1] = 1'b0;
    @(negedge clock);
    clrn = 1'b1;
    @(posedge clock); #1;
    check("post_rst_stall", bs.stall, 0);
    run_op(0, 0, -32'sd9, -32'sd9, 0);

    // Random traffic on both flavours
    for (int i = 0; i < 60; i++)
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick(), pick(),
             $urandom_range(0, 1) == 1);

    repeat (3) @(posedge clock);
    #1;
    check("s_queue_drained", q_s.size(), 0);
    check("u_queue_drained", q_u.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_exec_unit.md
# md_exec_unit

Parametrised iterative multiply/divide unit for the execute stage: accepts a mult or div request alongside the ALU, runs a radix-2 sequential algorithm over WIDTH cycles, and raises `stall` to freeze the pipeline latches until the result is ready. It generalises the execute stage's stall-and-hold handling with:

- configurable width and signedness,
- divide-by-zero and overflow exceptions,
- flush abort,
- a held result register.

## Interface
- `WIDTH`, 32: operand/result width; minimum 4.
- `SIGNED`, 1: 1 treats operands as two's complement; 0 treats them as unsigned.

- `clock` in 1: sole clock, rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `start_mult` in 1: request multiply; sampled only in IDLE.
- `start_div` in 1: request divide; sampled only in IDLE.
- `flush` in 1: abort the in-flight operation.
- `operand_a` in WIDTH: multiplicand or dividend; captured at the start edge.
- `operand_b` in WIDTH: multiplier or divisor; captured at the start edge.
- `result` out WIDTH: registered result; holds the last completed value.
- `result_rdy` out 1: one-cycle pulse; `result` is new this cycle.
- `exception` out 1: registered flag qualifying `result`; holds with `result`.
- `busy` out 1: high in CALC.
- `stall` out 1: combinational `((start_mult|start_div) & IDLE & ~flush) | busy`; drives pipeline latch disable.

## Operation
- States: IDLE, CALC, DONE. Encoding is defined in the package.
- **IDLE**
  - Start with `flush`=0: latch operands and op, clear counter, go to CALC.
  - `start_mult` and `start_div` together: multiply wins.
  - Divide with `operand_b`=0: go straight to DONE with result 0 and exception 1.
- **CALC**
  - Processes one bit per cycle on operand magnitudes. The counter runs 0..WIDTH-1.
  - Leaves for DONE when the counter reaches WIDTH-1.
  - Multiply uses a 2·WIDTH shift-add accumulator. Divide uses a restoring shift-subtract with a WIDTH+1 partial remainder.
- **DONE**
  - Apply the sign fix-up: product sign is a^b; quotient sign is a^b, truncated toward zero.
  - Write `result` and `exception`, pulse `result_rdy`, then return to IDLE.
- Multiply result: low WIDTH bits of the product.
  - Exception when the full product does not equal the sign-extension (SIGNED) or zero-extension (unsigned) of those low bits.
- Divide result: the quotient; the remainder is discarded.
  - SIGNED: MIN / -1 returns MIN with exception 1.
  - Divide by zero returns 0 with exception 1.
- Start requests in CALC or DONE are ignored. The issuer must hold them, which `stall` guarantees.
- `flush`:
  - In CALC or DONE: next state is IDLE, no `result_rdy`, and `result`/`exception` are unchanged.
  - In IDLE: suppresses any start that cycle.
  - `flush` has priority over every other input.
- Reset, asynchronous and at any time: state IDLE, counter 0, `result` 0, `exception` 0, `result_rdy` 0, `busy` 0; `stall` evaluates to 0 absent a start.

## Timing
- Cycle 0: start asserted and `stall`=1; operands captured at the end of cycle 0.
- Cycles 1..WIDTH: CALC, `busy`=1, `stall`=1.
- Cycle WIDTH+1: DONE, `result_rdy`=1, `stall`=0, so pipeline latches capture `result`.
- Latency is WIDTH+1 cycles start-to-ready, which is 33 for WIDTH=32.
- Divide by zero: `result_rdy` in cycle 1; `stall` high in cycle 0 only.
- Back-to-back: a start in the DONE cycle is ignored. The earliest accepted next start is cycle WIDTH+2.
- Operand changes after cycle 0 have no effect.

## Structure
- Package `md_pkg` holds:
  - the state typedef (IDLE=2'b00, CALC=2'b01, DONE=2'b10);
  - ALU opcode constants MULT=5'b00110 and DIV=5'b00111, used by the issuing stage to form the starts;
  - a `clog2`-based counter width.
- Sub-module `md_negate` is a WIDTH-parametrised conditional two's-complement negate. It is instanced for operand magnitudes and for the result sign fix-up.
- Remaining datapath and FSM live in `md_exec_unit`.

## Test plan
- Mult 7 × -6, WIDTH=32 SIGNED:
  - `result_rdy` only in cycle 33, `result`=0xFFFFFFD6, `exception`=0;
  - `stall` high in cycles 0..32, low in cycle 33.
- Div -100 / 7: `result`=0xFFFFFFF2 (-14), `exception`=0. Then div 0x80000000 / 0xFFFFFFFF: `result`=0x80000000, `exception`=1.
- Div 5 / 0: `result_rdy` in cycle 1, `result`=0, `exception`=1; `busy` never asserts.
- Mult 0x00010000 × 0x00010000: `result`=0, `exception`=1. Same test with SIGNED=0: 0xFFFFFFFF × 2 gives 0xFFFFFFFE, `exception`=1.
- Flush during div at cycle 10:
  - `busy`=0 from cycle 11; no `result_rdy`; `result` keeps its previous value;
  - a new mult 3×4 started in cycle 12 returns 12 in cycle 45;
  - `start_div` pulsed mid-CALC is ignored.
- `clrn` pulled low at cycle 5 of a mult: all outputs 0 immediately. After release, `stall` follows start only, and a new operation completes with nominal latency.
